subsurf_pass_sequencer: RTL and testbench

//  Top-level pass scheduler for the subdivision engine. On one start pulse it runs
//  NUM_STAGES pass units in order (stage 0 = neighbor builder, then downstream passes).

---
 rtl/subsurf_pass_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_subsurf_pass_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subsurf_pass_sequencer.sv
// subsurf_pass_sequencer
// Runs the subdivision pass units one after another from a single start pulse.
// Vertex and face counts are checked before any pass unit is started.
// Every pass is guarded by two watchdogs: one on the busy acknowledge, one on the run length.
// Only the unit that currently owns the sequence is connected to the shared object-RAM port.
module subsurf_pass_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int RAM_DEPTH     = 512,
  parameter int MAX_VERTS     = 128,
  parameter int ACK_TIMEOUT   = 4,
  parameter int STAGE_TIMEOUT = 65535,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              vertex_count,
  input  logic [31:0]              face_count,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [SW-1:0]            cur_stage,
  output logic [NUM_STAGES-1:0]    stage_start,
  input  logic [NUM_STAGES-1:0]    stage_busy,
  input  logic [NUM_STAGES-1:0]    stage_en,
  input  logic [4*NUM_STAGES-1:0]  stage_we,
  input  logic [9*NUM_STAGES-1:0]  stage_a,
  input  logic [32*NUM_STAGES-1:0] stage_di,
  output logic                     ram_en,
  output logic [3:0]               ram_we,
  output logic [8:0]               ram_a,
  output logic [31:0]              ram_di
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int WW = $clog2(STAGE_TIMEOUT + 1);
  localparam logic [31:0]   MAX_V     = 32'(MAX_VERTS);
  localparam logic [33:0]   DEPTH_W   = 34'(RAM_DEPTH);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(STAGE_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_STG  = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_ACK, S_RUN, S_DONE, S_ERR
  } state_e;

  state_e                  state_q;
  logic [31:0]             vcnt_q;
  logic [31:0]             fcnt_q;
  logic [SW-1:0]           cur_q;
  logic [AW-1:0]           ack_cnt_q;
  logic [WW-1:0]           wd_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [1:0]              err_code_q;
  logic [NUM_STAGES-1:0]   start_q;

  // Per-unit RAM request fields unpacked so the owner can be picked by index.
  logic [3:0]  we_arr [NUM_STAGES];
  logic [8:0]  a_arr  [NUM_STAGES];
  logic [31:0] di_arr [NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_unpack
    assign we_arr[k] = stage_we[4*k +: 4];
    assign a_arr[k]  = stage_a[9*k +: 9];
    assign di_arr[k] = stage_di[32*k +: 32];
  end

  // Each triangle takes three RAM words; widen to 34 bits so no face count can wrap.
  logic [33:0]           face_words_d;
  logic                  counts_bad_d;
  logic                  owner_busy_d;
  logic [SW-1:0]         next_stage_d;
  logic                  owns_ram_d;

  assign face_words_d = {2'b00, fcnt_q} + {1'b0, fcnt_q, 1'b0};
  assign counts_bad_d = (vcnt_q == 32'd0) || (vcnt_q > MAX_V) ||
                        (fcnt_q == 32'd0) || (face_words_d > DEPTH_W);
  assign owner_busy_d = stage_busy[cur_q];
  assign next_stage_d = cur_q + SW'(1);
  assign owns_ram_d   = (state_q == S_LAUNCH) || (state_q == S_ACK) || (state_q == S_RUN);

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cur_stage   = cur_q;
  assign stage_start = start_q;

  // Route the owning unit onto the RAM port and park the port whenever no pass is active.
  always_comb begin
    ram_en = 1'b0;
    ram_we = 4'd0;
    ram_a  = 9'd0;
    ram_di = 32'd0;
    if (owns_ram_d) begin
      ram_en = stage_en[cur_q];
      ram_we = we_arr[cur_q];
      ram_a  = a_arr[cur_q];
      ram_di = di_arr[cur_q];
    end else begin
      ram_en = 1'b0;
      ram_we = 4'd0;
      ram_a  = 9'd0;
      ram_di = 32'd0;
    end
  end

  // Sequencer FSM with registered status outputs, start pulses and watchdog counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vcnt_q     <= 32'd0;
      fcnt_q     <= 32'd0;
      cur_q      <= '0;
      ack_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      start_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vcnt_q     <= vertex_count;
            fcnt_q     <= face_count;
            err_code_q <= 2'd0;
            busy_q     <= 1'b1;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (counts_bad_d) begin
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            err_code_q <= 2'd1;
            state_q    <= S_ERR;
          end else begin
            cur_q     <= '0;
            start_q   <= NUM_STAGES'(1);
            ack_cnt_q <= '0;
            wd_cnt_q  <= '0;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          start_q   <= '0;
          ack_cnt_q <= '0;
          wd_cnt_q  <= '0;
          state_q   <= S_ACK;
        end
        S_ACK: begin
          if (owner_busy_d) begin
            state_q <= S_RUN;
          end else if (ack_cnt_q == ACK_LAST) begin
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            err_code_q <= 2'd2;
            state_q    <= S_ERR;
          end else begin
            ack_cnt_q <= ack_cnt_q + AW'(1);
          end
        end
        S_RUN: begin
          if (!owner_busy_d) begin
            if (cur_q == LAST_STG) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cur_q   <= next_stage_d;
              start_q <= NUM_STAGES'(1) << next_stage_d;
              state_q <= S_LAUNCH;
            end
          end else if (wd_cnt_q == WD_LAST) begin
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            err_code_q <= 2'd3;
            state_q    <= S_ERR;
          end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          cur_q   <= '0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          err_q   <= 1'b0;
          cur_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          start_q <= '0;
          cur_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subsurf_pass_sequencer.sv
// tb_subsurf_pass_sequencer
// Scoreboard bench: each run pushes the expected stage-start / done / err events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_subsurf_pass_sequencer;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     vertex_count = 32'd0;
  logic [31:0]     face_count = 32'd0;
  logic            busy, done, err;
  logic [1:0]      err_code;
  logic [1:0]      cur_stage;
  logic [NS-1:0]   stage_start;
  logic [NS-1:0]   stage_busy;
  logic [NS-1:0]   stage_en = '1;
  logic [4*NS-1:0] stage_we = '0;
  logic [9*NS-1:0] stage_a = '0;
  logic [32*NS-1:0] stage_di = '0;
  logic            ram_en;
  logic [3:0]      ram_we;
  logic [8:0]      ram_a;
  logic [31:0]     ram_di;

  int n_checks = 0;
  int n_fail = 0;
  int hold [NS];
  int sb_q [$];
  int cyc = 0;
  int last_start_cyc = 0;
  int last_end_cyc = 0;
  bit ram_en_seen = 1'b0;
  bit seen;

  always #5 clk = ~clk;

  subsurf_pass_sequencer #(.STAGE_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vertex_count(vertex_count), .face_count(face_count),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cur_stage(cur_stage), .stage_start(stage_start), .stage_busy(stage_busy),
    .stage_en(stage_en), .stage_we(stage_we), .stage_a(stage_a), .stage_di(stage_di),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di)
  );

  // Stub pass units: busy rises the cycle after start and holds hold[k] cycles (0 = never).
  for (genvar k = 0; k < NS; k++) begin : g_stub
    logic b = 1'b0;
    int   rem = 0;
    assign stage_busy[k] = b;
    always @(posedge clk) begin
      if (stage_start[k] && hold[k] > 0) begin
        b   <= 1'b1;
        rem <= hold[k] - 1;
      end else if (b) begin
        if (rem == 0) b <= 1'b0;
        else rem <= rem - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Event codes: 10+k = start of stage k, 1 = done, 20+c = err with code c, 99 = bad start vector.
  task automatic sb_pop(input int obs);
    if (sb_q.size() == 0) check_eq("sb_unexpected", obs, 32'hFFFF_FFFF);
    else check_eq("sb_event", obs, sb_q.pop_front());
  endtask

  task automatic push_run(input int nstarts, input int end_code);
    for (int i = 0; i < nstarts; i++) sb_q.push_back(10 + i);
    if (end_code != 0) sb_q.push_back(end_code);
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    int idx;
    cyc++;
    if (rst_n) begin
      if (stage_start != '0) begin
        idx = 99;
        if ($countones(stage_start) == 1) begin
          for (int i = 0; i < NS; i++) if (stage_start[i]) idx = 10 + i;
        end
        sb_pop(idx);
        last_start_cyc = cyc;
      end
      if (done) begin
        sb_pop(1);
        last_end_cyc = cyc;
      end
      if (err) begin
        sb_pop(20 + int'(err_code));
        last_end_cyc = cyc;
      end
      if (ram_en) ram_en_seen = 1'b1;
    end
  end

  task automatic do_start(input logic [31:0] v, input logic [31:0] f);
    @(negedge clk);
    vertex_count = v;
    face_count   = f;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done || err) got = 1'b1;
    end
    if (!got) check_eq("wait_end_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_stage(input logic [NS-1:0] mask, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (stage_start == mask) got = 1'b1;
    end
    if (!got) check_eq("wait_stage_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int bad_v [5];
    int bad_f [5];
    bad_v = '{0, 200, 129, 12, 12};
    bad_f = '{20, 20, 20, 0, 171};
    for (int k = 0; k < NS; k++) begin
      hold[k] = 10;
      stage_we[4*k +: 4]  = 4'(1 << k);
      stage_a[9*k +: 9]   = 9'(50 * k + 7);
      stage_di[32*k +: 32] = 32'hC0DE_0000 + 32'(k * 32'h1111);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done_err", {done, err}, 2'b00);
    check_eq("rst_err_code", err_code, 2'd0);
    check_eq("rst_cur_stage", cur_stage, 2'd0);
    check_eq("rst_stage_start", stage_start, 4'd0);
    check_eq("rst_ram", {ram_en, ram_we, ram_a, ram_di}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: normal four-stage run
    push_run(4, 1);
    do_start(32'd12, 32'd20);
    check_eq("t1_busy_after_start", busy, 1'b1);
    wait_end(300, seen);
    check_eq("t1_done_pulse", done, 1'b1);
    check_eq("t1_busy_with_done", busy, 1'b0);
    @(negedge clk);
    check_eq("t1_busy_after_done", busy, 1'b0);
    check_eq("t1_done_one_cycle", done, 1'b0);
    check_eq("t1_sb_empty", sb_q.size(), 0);

    // 2: bad count table, then the largest legal counts
    ram_en_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_run(0, 21);
      do_start(32'(bad_v[i]), 32'(bad_f[i]));
      wait_end(50, seen);
      check_eq("t2_err_code", err_code, 2'd1);
    end
    check_eq("t2_ram_en_never", ram_en_seen, 1'b0);
    push_run(4, 1);
    do_start(32'd128, 32'd170);
    wait_end(300, seen);
    check_eq("t2_boundary_ok_code", err_code, 2'd0);
    check_eq("t2_sb_empty", sb_q.size(), 0);

    // 3: stage 2 never acknowledges
    hold[2] = 0;
    push_run(3, 22);
    do_start(32'd12, 32'd20);
    wait_end(300, seen);
    check_eq("t3_err_code", err_code, 2'd2);
    check_eq("t3_err_latency", last_end_cyc - last_start_cyc, 5);
    @(negedge clk);
    check_eq("t3_cur_stage_zero", cur_stage, 2'd0);
    repeat (2) @(negedge clk);
    check_eq("t3_err_code_held", err_code, 2'd2);
    check_eq("t3_sb_empty", sb_q.size(), 0);
    hold[2] = 10;

    // 4: RAM ownership
    stage_en = 4'b1010;
    push_run(4, 1);
    do_start(32'd12, 32'd20);
    check_eq("t4_ram_en_check", ram_en, 1'b0);
    wait_stage(4'b0001, 50);
    check_eq("t4_ram_en_stage0", ram_en, 1'b0);
    wait_stage(4'b0010, 50);
    check_eq("t4_ram_en_stage1", ram_en, 1'b1);
    check_eq("t4_ram_we", ram_we, 4'b0010);
    check_eq("t4_ram_a", ram_a, 9'd57);
    check_eq("t4_ram_di", ram_di, 32'hC0DE_1111);
    @(negedge clk);
    check_eq("t4_ram_a_ack", ram_a, 9'd57);
    wait_end(300, seen);
    check_eq("t4_ram_en_done", ram_en, 1'b0);
    @(negedge clk);
    check_eq("t4_ram_en_idle", ram_en, 1'b0);
    check_eq("t4_err_code_cleared", err_code, 2'd0);
    stage_en = '1;

    // 5: async reset in stage 2, then a fresh run
    push_run(3, 0);
    do_start(32'd12, 32'd20);
    wait_stage(4'b0100, 100);
    repeat (3) @(negedge clk);
    check_eq("t5_busy_before", busy, 1'b1);
    check_eq("t5_ram_en_before", ram_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_busy_async", busy, 1'b0);
    check_eq("t5_ram_en_async", ram_en, 1'b0);
    check_eq("t5_cur_stage_async", cur_stage, 2'd0);
    check_eq("t5_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_run(4, 1);
    do_start(32'd12, 32'd20);
    wait_end(300, seen);
    check_eq("t5_rerun_done", done, 1'b1);
    check_eq("t5_sb_empty2", sb_q.size(), 0);

    // 6: start ignored in RUN and on the done cycle; then stage watchdog
    push_run(4, 1);
    do_start(32'd12, 32'd20);
    wait_stage(4'b0010, 50);
    repeat (3) @(negedge clk);
    vertex_count = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(300, seen);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t6_busy_after_done_start", busy, 1'b0);
    @(negedge clk);
    check_eq("t6_busy_still_idle", busy, 1'b0);
    check_eq("t6_sb_empty", sb_q.size(), 0);
    hold[1] = 20;
    push_run(2, 23);
    do_start(32'd12, 32'd20);
    wait_end(300, seen);
    check_eq("t6_err_code", err_code, 2'd3);
    check_eq("t6_wd_latency", last_end_cyc - last_start_cyc, 18);
    check_eq("t6_sb_empty2", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
